// File: rtl/cadd_pipe_if.sv
// Stream bundle for cadd_pipe: the input operand handshake and the saturated result handshake.
// master drives operands and out_ready; slave is the adder pipeline.
interface cadd_pipe_if #(
    parameter int DW = 16,
    parameter int OW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] opa_r;
    logic [DW-1:0] opa_i;
    logic [DW-1:0] opb_r;
    logic [DW-1:0] opb_i;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_r;
    logic [OW-1:0] out_i;
    logic [1:0]    out_sat;

    modport master (
        output in_valid, opa_r, opa_i, opb_r, opb_i, sub, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_sat
    );

    modport slave (
        input  in_valid, opa_r, opa_i, opb_r, opb_i, sub, out_ready,
        output in_ready, out_valid, out_r, out_i, out_sat
    );
endinterface

// File: rtl/cadd_pipe.sv
// Two-stage elastic complex add/subtract with saturation to OW bits (DW <= OW <= DW+1, CNT_W >= 2).
// Optional clip-event counter enabled by defining CADD_SAT_CNT_EN; otherwise sat_cnt reads 0.
module cadd_pipe #(
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cadd_pipe_if.slave       bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_cnt
);
    localparam int SW = DW + 1;

    logic live_reg;
    logic v1_reg;
    logic v2_reg;
    logic rdy1;
    logic rdy2;
    logic in_hs;
    logic ld2;

    // live_reg keeps in_ready low until the first edge after reset release.
    assign rdy2         = !v2_reg || bus.out_ready;
    assign rdy1         = !v1_reg || rdy2;
    assign bus.in_ready = live_reg && rdy1;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign ld2          = rdy2 && v1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_reg <= 1'b0;
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
        end else begin
            live_reg <= 1'b1;
            if (rdy1) begin
                v1_reg <= in_hs;
            end
            if (rdy2) begin
                v2_reg <= v1_reg;
            end
        end
    end

    logic [DW-1:0] opa [2];
    logic [DW-1:0] opb [2];

    assign opa[0] = bus.opa_r;
    assign opa[1] = bus.opa_i;
    assign opb[0] = bus.opb_r;
    assign opb[1] = bus.opb_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [SW-1:0] a_ext;
            logic signed [SW-1:0] b_ext;
            logic signed [SW-1:0] sum_next;
            logic signed [SW-1:0] sum_reg;
            logic [OW-1:0]        res_next;
            logic [OW-1:0]        res_reg;
            logic                 clip_next;
            logic                 clip_reg;

            assign a_ext    = {opa[gi][DW-1], opa[gi]};
            assign b_ext    = {opb[gi][DW-1], opb[gi]};
            assign sum_next = bus.sub ? (a_ext - b_ext) : (a_ext + b_ext);

            if (OW == SW) begin : g_wide
                assign res_next  = sum_reg;
                assign clip_next = 1'b0;
            end else begin : g_clamp
                // The top two bits of the DW+1 sum disagree exactly when it leaves the OW range.
                always_comb begin
                    res_next  = sum_reg[OW-1:0];
                    clip_next = 1'b0;
                    if (sum_reg[SW-1] != sum_reg[SW-2]) begin
                        clip_next = 1'b1;
                        res_next  = sum_reg[SW-1] ? {1'b1, {(OW-1){1'b0}}}
                                                  : {1'b0, {(OW-1){1'b1}}};
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_reg  <= '0;
                    res_reg  <= '0;
                    clip_reg <= 1'b0;
                end else begin
                    if (in_hs) begin
                        sum_reg <= sum_next;
                    end
                    if (ld2) begin
                        res_reg  <= res_next;
                        clip_reg <= clip_next;
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = v2_reg;
    assign bus.out_r     = g_comp[0].res_reg;
    assign bus.out_i     = g_comp[1].res_reg;
    assign bus.out_sat   = {g_comp[1].clip_reg, g_comp[0].clip_reg};

`ifdef CADD_SAT_CNT_EN
    logic             out_hs;
    logic [1:0]       pop;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    assign out_hs  = v2_reg && bus.out_ready;
    assign pop     = {1'b0, g_comp[0].clip_reg} + {1'b0, g_comp[1].clip_reg};
    assign cnt_sum = {1'b0, cnt_reg} + {{(CNT_W-1){1'b0}}, pop};

    // Clear wins over a same-cycle increment; the carry out of cnt_sum pins the count at all-ones.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr_cnt) begin
            cnt_next = '0;
        end else if (out_hs) begin
            cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign sat_cnt = cnt_reg;
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_cadd_pipe.sv
// Bench for cadd_pipe: two instances (OW=16 with a 3-bit counter, OW=17) share one stimulus stream
// and are checked every cycle against an arithmetic queue model.
module tb_cadd_pipe;
    localparam int CW0 = 3;
    localparam int CW1 = 16;
`ifdef CADD_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int r;
        int i;
        int sat;
        int cyc;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        d_iv, d_sub, d_ordy, d_clr;
    logic [15:0] d_ar, d_ai, d_br, d_bi;
    logic [CW0-1:0] sat_cnt0;
    logic [CW1-1:0] sat_cnt1;

    cadd_pipe_if #(.DW(16), .OW(16)) bus0 ();
    cadd_pipe_if #(.DW(16), .OW(17)) bus1 ();

    assign bus0.in_valid  = d_iv;
    assign bus0.opa_r     = d_ar;
    assign bus0.opa_i     = d_ai;
    assign bus0.opb_r     = d_br;
    assign bus0.opb_i     = d_bi;
    assign bus0.sub       = d_sub;
    assign bus0.out_ready = d_ordy;
    assign bus1.in_valid  = d_iv;
    assign bus1.opa_r     = d_ar;
    assign bus1.opa_i     = d_ai;
    assign bus1.opb_r     = d_br;
    assign bus1.opb_i     = d_bi;
    assign bus1.sub       = d_sub;
    assign bus1.out_ready = d_ordy;

    cadd_pipe #(.DW(16), .OW(16), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .clr_cnt(d_clr), .sat_cnt(sat_cnt0));
    cadd_pipe #(.DW(16), .OW(17), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .clr_cnt(d_clr), .sat_cnt(sat_cnt1));

    smp_t exp0[$], exp1[$], obs0[$], obs1[$];
    int   cyc, cnt0_m, cnt1_m, n_checks, n_err, acc_cyc, k;
    bit   last_ihs;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: exact integer sum/difference, clamped to the signed OW range.
    function automatic smp_t model(input int ow, input logic [15:0] ar, ai, br, bi,
                                   input logic sb, input int c);
        smp_t s;
        int   v[2];
        int   maxv, minv;
        maxv = (1 << (ow - 1)) - 1;
        minv = -(1 << (ow - 1));
        v[0] = sb ? int'($signed(ar)) - int'($signed(br)) : int'($signed(ar)) + int'($signed(br));
        v[1] = sb ? int'($signed(ai)) - int'($signed(bi)) : int'($signed(ai)) + int'($signed(bi));
        s.sat = 0;
        for (int n = 0; n < 2; n++) begin
            if (v[n] > maxv) begin
                v[n] = maxv;
                s.sat |= (1 << n);
            end else if (v[n] < minv) begin
                v[n] = minv;
                s.sat |= (1 << n);
            end
        end
        s.r   = v[0];
        s.i   = v[1];
        s.cyc = c;
        return s;
    endfunction

    function automatic int popc(input int sat);
        return (sat & 1) + ((sat >> 1) & 1);
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'($urandom_range(15));
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: check outputs at negedge, then advance the model across the rising edge.
    task automatic cycle();
        bit   ihs0, ihs1, ohs0, ohs1;
        smp_t s0, s1;
        @(negedge clk);
        check("in_ready0", longint'(bus0.in_ready), longint'((exp0.size() < 2) || d_ordy));
        check("in_ready1", longint'(bus1.in_ready), longint'((exp1.size() < 2) || d_ordy));
        check("out_valid0", longint'(bus0.out_valid),
              longint'(exp0.size() > 0 && exp0[0].cyc <= cyc - 2));
        check("out_valid1", longint'(bus1.out_valid),
              longint'(exp1.size() > 0 && exp1[0].cyc <= cyc - 2));
        if (bus0.out_valid && exp0.size() > 0) begin
            check("out_r0", longint'($signed(bus0.out_r)), longint'(exp0[0].r));
            check("out_i0", longint'($signed(bus0.out_i)), longint'(exp0[0].i));
            check("out_sat0", longint'(bus0.out_sat), longint'(exp0[0].sat));
        end
        if (bus1.out_valid && exp1.size() > 0) begin
            check("out_r1", longint'($signed(bus1.out_r)), longint'(exp1[0].r));
            check("out_i1", longint'($signed(bus1.out_i)), longint'(exp1[0].i));
            check("out_sat1", longint'(bus1.out_sat), longint'(exp1[0].sat));
        end
        check("sat_cnt0", longint'(sat_cnt0), longint'(cnt0_m));
        check("sat_cnt1", longint'(sat_cnt1), longint'(cnt1_m));
        ihs0 = d_iv && bus0.in_ready;
        ihs1 = d_iv && bus1.in_ready;
        ohs0 = bus0.out_valid && d_ordy;
        ohs1 = bus1.out_valid && d_ordy;
        if (ohs0) begin
            obs0.push_back('{int'($signed(bus0.out_r)), int'($signed(bus0.out_i)),
                             int'(bus0.out_sat), cyc});
            $display("txn cyc=%0d ow16=(%0d,%0d) sat=%b ow17=(%0d,%0d) sat=%b", cyc,
                     $signed(bus0.out_r), $signed(bus0.out_i), bus0.out_sat,
                     $signed(bus1.out_r), $signed(bus1.out_i), bus1.out_sat);
        end
        if (ohs1) begin
            obs1.push_back('{int'($signed(bus1.out_r)), int'($signed(bus1.out_i)),
                             int'(bus1.out_sat), cyc});
        end
        @(posedge clk);
        s0 = '{0, 0, 0, 0};
        s1 = '{0, 0, 0, 0};
        if (ohs0 && exp0.size() > 0) s0 = exp0.pop_front();
        if (ohs1 && exp1.size() > 0) s1 = exp1.pop_front();
        if (CNT_EN) begin
            if (d_clr) begin
                cnt0_m = 0;
                cnt1_m = 0;
            end else begin
                if (ohs0) cnt0_m = (cnt0_m + popc(s0.sat) > 7) ? 7 : cnt0_m + popc(s0.sat);
                if (ohs1) cnt1_m = (cnt1_m + popc(s1.sat) > 65535) ? 65535 : cnt1_m + popc(s1.sat);
            end
        end
        if (ihs0) begin
            exp0.push_back(model(16, d_ar, d_ai, d_br, d_bi, d_sub, cyc));
            acc_cyc = cyc;
        end
        if (ihs1) exp1.push_back(model(17, d_ar, d_ai, d_br, d_bi, d_sub, cyc));
        last_ihs = ihs0;
        cyc++;
        #1;
    endtask

    task automatic send(input logic [15:0] ar, ai, br, bi, input logic sb);
        d_iv  = 1'b1;
        d_ar  = ar;
        d_ai  = ai;
        d_br  = br;
        d_bi  = bi;
        d_sub = sb;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_ihs) break;
        end
        check("send_accept", longint'(last_ihs), 1);
        d_iv = 1'b0;
    endtask

    task automatic idle(input int n);
        d_iv = 1'b0;
        repeat (n) cycle();
    endtask

    // Asynchronous reset assertion away from the clock edge; release on a falling edge.
    task automatic reset_dut();
        d_iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid0", longint'(bus0.out_valid), 0);
        check("rst_out_r0", longint'(bus0.out_r), 0);
        check("rst_out_i0", longint'(bus0.out_i), 0);
        check("rst_out_sat0", longint'(bus0.out_sat), 0);
        check("rst_sat_cnt0", longint'(sat_cnt0), 0);
        check("rst_out_valid1", longint'(bus1.out_valid), 0);
        check("rst_out_r1", longint'(bus1.out_r), 0);
        exp0.delete();
        exp1.delete();
        cnt0_m = 0;
        cnt1_m = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        cnt0_m   = 0;
        cnt1_m   = 0;
        acc_cyc  = 0;
        last_ihs = 1'b0;
        d_iv = 1'b0; d_sub = 1'b0; d_ordy = 1'b1; d_clr = 1'b0;
        d_ar = '0; d_ai = '0; d_br = '0; d_bi = '0;
        reset_dut();

        // Double clip on the OW=16 instance, none on OW=17; two-cycle latency.
        obs0.delete(); obs1.delete();
        send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        k = acc_cyc;
        idle(4);
        check("tp1_count", obs0.size(), 1);
        check("tp1_latency", obs0[0].cyc - k, 2);
        check("tp1_r", obs0[0].r, 32767);
        check("tp1_i", obs0[0].i, -32768);
        check("tp1_sat", obs0[0].sat, 3);
        check("tp1_r17", obs1[0].r, 36864);
        check("tp1_i17", obs1[0].i, -32769);
        check("tp1_sat17", obs1[0].sat, 0);

        // Subtract, with a real-only clip followed by an exact zero.
        obs0.delete(); obs1.delete();
        send(16'h8000, 16'd100, 16'h0001, 16'hFFCE, 1'b1);
        send(16'd5, 16'd5, 16'd5, 16'd5, 1'b1);
        idle(4);
        check("tp2_r", obs0[0].r, -32768);
        check("tp2_i", obs0[0].i, 150);
        check("tp2_sat", obs0[0].sat, 1);
        check("tp2_zero_r", obs0[1].r, 0);
        check("tp2_zero_i", obs0[1].i, 0);
        check("tp2_zero_sat", obs0[1].sat, 0);

        // Backpressure: three stalled cycles from the first out_valid, then a gap-free drain.
        obs0.delete(); obs1.delete();
        begin
            int stall;
            bit seen;
            stall = 0;
            seen  = 1'b0;
            k     = 0;
            for (int t = 0; t < 30; t++) begin
                d_iv  = (k < 6);
                d_ar  = 16'(k + 1);
                d_ai  = '0;
                d_br  = '0;
                d_bi  = '0;
                d_sub = 1'b0;
                if (!seen && bus0.out_valid) begin
                    seen  = 1'b1;
                    stall = 3;
                end
                d_ordy = (stall == 0);
                if (stall > 0) begin
                    #1;
                    check("bp_in_ready", longint'(bus0.in_ready), 0);
                    check("bp_hold", longint'($signed(bus0.out_r)), 1);
                    stall--;
                end
                cycle();
                if (last_ihs) k++;
            end
            d_iv = 1'b0;
            d_ordy = 1'b1;
        end
        check("bp_count", obs0.size(), 6);
        for (int j = 0; j < 6; j++) begin
            check("bp_order", obs0[j].r, j + 1);
            check("bp_nogap", obs0[j].cyc - obs0[0].cyc, j);
        end

        // Reset with both stages full: nothing may emerge afterwards.
        obs0.delete(); obs1.delete();
        d_ordy = 1'b0;
        send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        send(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        check("pre_rst_valid", longint'(bus0.out_valid), 1);
        check("pre_rst_ready", longint'(bus0.in_ready), 0);
        reset_dut();
        d_ordy = 1'b1;
        idle(6);
        check("post_rst_none0", obs0.size(), 0);
        check("post_rst_none1", obs1.size(), 0);

        // Clip counter on the 3-bit instance: 6, then pinned at 7, then a clear racing a handshake.
        for (int j = 0; j < 3; j++) send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        idle(4);
        check("cnt_six", longint'(sat_cnt0), CNT_EN ? 6 : 0);
        send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        idle(4);
        check("cnt_seven", longint'(sat_cnt0), CNT_EN ? 7 : 0);
        send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        idle(4);
        check("cnt_pinned", longint'(sat_cnt0), CNT_EN ? 7 : 0);
        send(16'h7000, 16'h8000, 16'h2000, 16'hFFFF, 1'b0);
        cycle();
        check("clr_with_hs", longint'(bus0.out_valid), 1);
        d_clr = 1'b1;
        cycle();
        d_clr = 1'b0;
        idle(1);
        check("cnt_cleared", longint'(sat_cnt0), 0);

        // Full-scale operands: OW=17 holds the exact result.
        obs0.delete(); obs1.delete();
        send(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b0);
        idle(4);
        check("ow17_r", obs1[0].r, 65534);
        check("ow17_i", obs1[0].i, -65536);
        check("ow17_sat", obs1[0].sat, 0);
        check("ow16_r", obs0[0].r, 32767);
        check("ow16_i", obs0[0].i, -32768);
        check("ow16_sat", obs0[0].sat, 3);

        // Random traffic with random backpressure and occasional clears.
        for (int t = 0; t < 800; t++) begin
            d_iv   = ($urandom_range(3) != 0);
            d_ordy = ($urandom_range(3) != 0);
            d_clr  = ($urandom_range(31) == 0);
            d_sub  = 1'($urandom_range(1));
            d_ar   = rnd_op();
            d_ai   = rnd_op();
            d_br   = rnd_op();
            d_bi   = rnd_op();
            cycle();
        end
        d_clr  = 1'b0;
        d_ordy = 1'b1;
        idle(5);
        check("drain0", exp0.size(), 0);
        check("drain1", exp1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
